a0_trace_buffer: RTL and testbench
==================================

// Module: a0_trace_buffer
// PURPOSE
//  Downstream consumer of the CPU top-level a0 output. Samples a0 every cycle and
//  pushes an entry {value, cycle stamp} into a FIFO whenever a0 changes. A
//  valid/ready port drains the FIFO to the testbench or display driver.
//  The core is never stalled; entries that arrive while the FIFO is full are dropped and flagged.
// PARAMETERS
//  DATA_W   32  width of a0 sample
//  DEPTH    16  FIFO entries; power of two, >=2
//  STAMP_W  16  width of free-running cycle stamp
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  a0         in   DATA_W   a0 from CPU top
//  en         in   1        capture enable
//  out_ready  in   1        consumer accepts head entry
//  clr_ovf    in   1        synchronous clear of overflow flag
//  out_valid  out  1        FIFO non-empty; head entry presented
//  out_data   out  DATA_W   head entry a0 value
//  out_stamp  out  STAMP_W  head entry cycle stamp
//  count      out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
//  overflow   out  1        sticky: a push was dropped
// BEHAVIOUR
//  - Reset (async): wr_ptr, rd_ptr, count, overflow, prev_a0 and stamp counter all 0.
//    Outputs: out_valid=0, count=0, overflow=0. FIFO RAM is not reset.
//  - prev_a0 <= a0 every cycle regardless of en. change = (a0 != prev_a0).
//  - push = en & change. pop = out_valid & out_ready.
//  - Push writes {a0, stamp} at wr_ptr on the edge. Entry is visible on
//    out_valid/out_data in the following cycle (1-cycle latency, no bypass).
//  - out_data/out_stamp are driven from mem[rd_ptr] (show-ahead) and hold steady
//    while out_valid=1 and out_ready=0.
//  - When out_valid=0, out_data/out_stamp are undefined; checks apply only when valid.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - count: +1 on accepted push only, -1 on pop only, unchanged when both occur.
//  - Full (count==DEPTH):
//    - push with pop in the same cycle is accepted (slot freed the same edge).
//    - push without pop is dropped and overflow<=1.
//  - Empty: out_ready is ignored and no pop occurs. Push and ready in the same cycle
//    does not bypass; the entry pops no earlier than the next cycle.
//  - overflow is sticky until clr_ovf=1. If clr_ovf and a drop occur in the same
//    cycle, the drop wins and overflow=1.
//  - Stamp counter increments every cycle and wraps 2^STAMP_W-1 -> 0. An entry's stamp
//    is the counter value in the cycle the change is detected.
//  - Reset mid-operation discards all queued entries immediately (out_valid falls
//    asynchronously). After release, the first a0!=0 counts as a change versus prev_a0=0.
// CONFIGURATION
//  TRACE_STAMP_EN defined:
//    - stamp counter and the stamp field of each FIFO entry are present; out_stamp as above.
//  TRACE_STAMP_EN undefined:
//    - no counter and no stamp storage.
//    - out_stamp is tied to 0; all other behaviour is identical.
// TESTING
//  1 Reset, en=1, a0 held at 0 for 20 cycles -> out_valid=0, count=0.
//  2 a0: 0->5 at cycle 3, 5->9 at cycle 7, out_ready=1 -> two pops in order:
//    {5,stamp 3} then {9,stamp 7}.
//  3 out_ready=0, a0 changes 17 times (DEPTH=16) -> count=16, overflow=1, 16th
//    entry retained, 17th lost; then clr_ovf -> overflow=0.
//  4 FIFO full, push and pop in the same cycle -> count stays 16, overflow stays 0,
//    and the new entry appears after 15 further pops.
//  5 en=0 while a0 toggles, then en=1 with a0 static -> no entries captured.
//  6 Assert rst with count=4 -> out_valid=0 and count=0 before the next edge;
//    after release, a0=3 -> one entry with value 3.

Source files
------------

// File: rtl/a0_trace_buffer.sv
// a0 change tracer: captures {a0, cycle stamp} into a show-ahead FIFO on change.
// Optional stamp storage enabled by defining TRACE_STAMP_EN.
module a0_trace_buffer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        a0,
  input  logic                     en,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [STAMP_W-1:0]       out_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] prev_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic change;
  logic push_req;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;

  // Capture and handshake qualifiers
  always_comb begin
    change   = (a0 != prev_q);
    push_req = en & change;
    full     = (count_q == FULL);
    pop      = (count_q != '0) & out_ready;
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  // Next-state for pointers, occupancy and sticky overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Control state; a0 history tracks every cycle regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= a0;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Data storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= a0;
  end

`ifdef TRACE_STAMP_EN
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [STAMP_W-1:0] smem_q [DEPTH];

  // Free-running stamp, wraps naturally
  always_comb begin
    stamp_d = stamp_q + 1'b1;
  end

  // Stamp counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stamp_q <= '0;
    else     stamp_q <= stamp_d;
  end

  // Stamp field stored alongside each entry
  always_ff @(posedge clk) begin
    if (push_ok) smem_q[wr_ptr_q] <= stamp_q;
  end

  assign out_stamp = smem_q[rd_ptr_q];
`else
  assign out_stamp = '0;
`endif

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_a0_trace_buffer.sv
// Scoreboard bench for a0_trace_buffer: directed a0 patterns,
// expected entries queued at stimulus time, checked on every pop.
module tb_a0_trace_buffer;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 16;

  typedef struct {
    logic [DATA_W-1:0]  d;
    logic [STAMP_W-1:0] s;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DATA_W-1:0] a0 = '0;
  logic en = 1'b1;
  logic out_ready = 1'b0;
  logic clr_ovf = 1'b0;
  logic out_valid;
  logic [DATA_W-1:0] out_data;
  logic [STAMP_W-1:0] out_stamp;
  logic [$clog2(DEPTH):0] cnt;
  logic overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  ent_t exp_q[$];

  a0_trace_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W)
  ) dut (
    .clk(clk), .rst(rst), .a0(a0), .en(en),
    .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_data(out_data),
    .out_stamp(out_stamp), .count(cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: posedges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [STAMP_W-1:0] exp_stamp();
`ifdef TRACE_STAMP_EN
    return STAMP_W'(cyc);
`else
    return '0;
`endif
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(logic [DATA_W-1:0] v);
    ent_t e;
    e.d = v;
    e.s = exp_stamp();
    exp_q.push_back(e);
  endtask

  task automatic drain(int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: compare head entry whenever a pop is about to happen
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got data %0d, none expected",
                 out_data);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_data", out_data, e.d);
        chk("pop_stamp", out_stamp, e.s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, a0 static at zero
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (5) step();
      chk("t1_valid", out_valid, 0);
      chk("t1_count", cnt, 0);
    end
    chk("t1_ovf", overflow, 0);

    // 2: changes at cycles 3 and 7 drain in order
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    a0 = 5;
    expect_push(5);
    repeat (4) step();
    a0 = 9;
    expect_push(9);
    drain(10);
    step();
    chk("t2_count", cnt, 0);

    // 3: 17 changes into a 16-deep FIFO
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 17; i++) begin
      a0 = 100 + i;
      if (i < 16) expect_push(100 + i);
      step();
    end
    chk("t3_count", cnt, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_valid", out_valid, 1);
    chk("t3_head", out_data, 100);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t3_clr", overflow, 0);
    a0 = 150;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t3_drop_wins", overflow, 1);
    chk("t3_count2", cnt, 16);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t3_clr2", overflow, 0);

    // 4: push and pop together while full
    out_ready = 1'b1;
    a0 = 200;
    expect_push(200);
    step();
    out_ready = 1'b0;
    chk("t4_count", cnt, 16);
    chk("t4_ovf", overflow, 0);
    out_ready = 1'b1;
    drain(40);
    step();
    chk("t4_count0", cnt, 0);
    chk("t4_valid0", out_valid, 0);

    // 5: capture disabled while toggling, then static
    out_ready = 1'b0;
    en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a0 = i;
      step();
    end
    en = 1'b1;
    repeat (4) step();
    chk("t5_count", cnt, 0);
    chk("t5_valid", out_valid, 0);

    // 6: reset with queued entries, then a single new entry
    for (int i = 0; i < 4; i++) begin
      a0 = 10 + i;
      expect_push(10 + i);
      step();
    end
    chk("t6_count4", cnt, 4);
    rst = 1'b1;
    a0 = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_count", cnt, 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    a0 = 3;
    expect_push(3);
    step();
    chk("t6_count1", cnt, 1);
    out_ready = 1'b1;
    drain(10);
    step();
    chk("t6_count0", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
